// File: rtl/exc_sched_pkg.sv
// Shared types and constants for the exception/interrupt scheduler that feeds cp0.
package exc_sched_pkg;

  localparam int EXC_CODE_WIDTH        = 5;
  localparam int INT_MASK_WIDTH        = 8;
  localparam int HW_INT_WIDTH          = 6;
  localparam int EXC_SCHED_STATE_WIDTH = 2;

  typedef logic [EXC_CODE_WIDTH-1:0] exc_code_t;

  localparam exc_code_t EC_INT  = 5'h00;
  localparam exc_code_t EC_TLBL = 5'h02;
  localparam exc_code_t EC_SYS  = 5'h08;
  localparam exc_code_t EC_ERET = 5'h1e;
  localparam exc_code_t EC_NONE = 5'h1f;

  typedef enum logic [EXC_SCHED_STATE_WIDTH-1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } exc_state_e;

  typedef struct packed {
    exc_code_t   code;
    logic [31:0] epc;
    logic [31:0] badvaddr;
  } exc_evt_t;

endpackage

// File: rtl/exc_sched_int_sync.sv
// Multi-flop synchronizer bank for asynchronous level interrupt lines.
module exc_sched_int_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain_d, chain_q;

  // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    chain_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      chain_d[i] = chain_q[i-1];
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chain_q <= '0;
    else      chain_q <= chain_d;
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/exc_sched.sv
// Funnels synchronous exceptions, ERET and interrupts into one cp0 event, then
// holds the pipeline stalled and flushed until cp0 reports its jump.
module exc_sched
  import exc_sched_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int JMP_TIMEOUT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [HW_INT_WIDTH-1:0]   hw_int,
  input  logic                      int_timer_req,
  input  logic [1:0]                sw_int,
  input  logic [31:0]               status,
  input  logic                      req_valid,
  input  logic [EXC_CODE_WIDTH-1:0] req_code,
  input  logic [31:0]               req_epc,
  input  logic [31:0]               req_badvaddr,
  input  logic [31:0]               inst_epc,
  input  logic                      inst_valid,
  output logic [INT_MASK_WIDTH-1:0] cause_ip,
  output logic [EXC_CODE_WIDTH-1:0] exc_code,
  output logic [31:0]               exc_epc,
  output logic [31:0]               exc_badvaddr,
  input  logic                      exc_jmp_flag,
  output logic                      stall,
  output logic                      flush,
  output logic                      timeout_err
);

  localparam int CNT_W = $clog2(JMP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(JMP_TIMEOUT);

  logic [HW_INT_WIDTH-1:0] hw_int_sync;
  exc_state_e              state_d, state_q;
  exc_evt_t                evt_d, evt_q;
  logic [CNT_W-1:0]        cnt_d, cnt_q, cnt_inc;
  logic                    int_take;
  logic                    unused_status;

  exc_sched_int_sync #(
    .WIDTH  (HW_INT_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_int_sync (
    .clk (clk),
    .rst (rst),
    .d   (hw_int),
    .q   (hw_int_sync)
  );

  // Timer request is already synchronous to clk, so it bypasses the synchronizer.
  assign cause_ip = {hw_int_sync[5] | int_timer_req, hw_int_sync[4:0], sw_int};
  assign int_take = (|(cause_ip & status[15:8])) & status[0] & ~status[1] & inst_valid;
  assign unused_status = ^{status[31:16], status[7:2]};

  assign cnt_inc = (cnt_q == TIMEOUT_VAL) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    evt_d       = evt_q;
    cnt_d       = cnt_q;
    stall       = 1'b1;
    flush       = 1'b1;
    timeout_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        flush = 1'b0;
        stall = req_valid | int_take;
        cnt_d = '0;
        // A synchronous exception outranks an interrupt raised in the same cycle.
        if (req_valid) begin
          evt_d   = '{code: req_code, epc: req_epc, badvaddr: req_badvaddr};
          state_d = ST_ISSUE;
        end else if (int_take) begin
          evt_d   = '{code: EC_INT, epc: inst_epc, badvaddr: 32'h0};
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        evt_d.code = EC_NONE;
        cnt_d      = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (exc_jmp_flag) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_VAL) begin
            timeout_err = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      evt_q   <= '{code: EC_NONE, epc: 32'h0, badvaddr: 32'h0};
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      evt_q   <= evt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign exc_code     = evt_q.code;
  assign exc_epc      = evt_q.epc;
  assign exc_badvaddr = evt_q.badvaddr;

endmodule

// File: tb/tb_exc_sched.sv
// Directed bench for exc_sched: a per-cycle vector table plus short hand-written
// sequences for timeout and reset during WAIT.
module tb_exc_sched;
  import exc_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  hw_int;
  logic        int_timer_req;
  logic [1:0]  sw_int;
  logic [31:0] status;
  logic        req_valid;
  logic [4:0]  req_code;
  logic [31:0] req_epc;
  logic [31:0] req_badvaddr;
  logic [31:0] inst_epc;
  logic        inst_valid;
  logic [7:0]  cause_ip;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc;
  logic [31:0] exc_badvaddr;
  logic        exc_jmp_flag;
  logic        stall;
  logic        flush;
  logic        timeout_err;

  int n_vec = 0;
  int n_err = 0;

  exc_sched #(.SYNC_STAGES(2), .JMP_TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .hw_int        (hw_int),
    .int_timer_req (int_timer_req),
    .sw_int        (sw_int),
    .status        (status),
    .req_valid     (req_valid),
    .req_code      (req_code),
    .req_epc       (req_epc),
    .req_badvaddr  (req_badvaddr),
    .inst_epc      (inst_epc),
    .inst_valid    (inst_valid),
    .cause_ip      (cause_ip),
    .exc_code      (exc_code),
    .exc_epc       (exc_epc),
    .exc_badvaddr  (exc_badvaddr),
    .exc_jmp_flag  (exc_jmp_flag),
    .stall         (stall),
    .flush         (flush),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [5:0]  hw;
    logic        timer;
    logic [1:0]  sw;
    logic [31:0] st;
    logic        req;
    logic [4:0]  code;
    logic [31:0] epc;
    logic [31:0] bv;
    logic        iv;
    logic        jmp;
    logic [7:0]  e_cause;
    logic [4:0]  e_code;
    logic [31:0] e_epc;
    logic [31:0] e_bv;
    logic        e_stall;
    logic        e_flush;
  } vec_t;

  function automatic vec_t mk(input logic [5:0] hw, input logic timer, input logic [1:0] sw,
                              input logic [31:0] st, input logic req, input logic [4:0] code,
                              input logic [31:0] epc, input logic [31:0] bv, input logic iv,
                              input logic jmp, input logic [7:0] e_cause, input logic [4:0] e_code,
                              input logic [31:0] e_epc, input logic [31:0] e_bv,
                              input logic e_stall, input logic e_flush);
    vec_t v;
    v.hw = hw; v.timer = timer; v.sw = sw; v.st = st; v.req = req; v.code = code;
    v.epc = epc; v.bv = bv; v.iv = iv; v.jmp = jmp; v.e_cause = e_cause; v.e_code = e_code;
    v.e_epc = e_epc; v.e_bv = e_bv; v.e_stall = e_stall; v.e_flush = e_flush;
    return v;
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    hw_int = v.hw; int_timer_req = v.timer; sw_int = v.sw; status = v.st;
    req_valid = v.req; req_code = v.code; req_epc = v.epc; req_badvaddr = v.bv;
    inst_valid = v.iv; exc_jmp_flag = v.jmp;
  endtask

  // Packs every observable output: cause, code, epc, badvaddr, stall, flush, timeout_err.
  function automatic logic [95:0] outs();
    return {15'h0, cause_ip, exc_code, exc_epc, exc_badvaddr, stall, flush, timeout_err};
  endfunction

  function automatic logic [95:0] exp_outs(input logic [7:0] c, input logic [4:0] k,
                                           input logic [31:0] e, input logic [31:0] b,
                                           input logic s, input logic f, input logic t);
    return {15'h0, c, k, e, b, s, f, t};
  endfunction

  localparam logic [31:0] S0 = 32'h0000_1001;  // IE, IM4 (hw_int[2])
  localparam logic [31:0] S1 = 32'h0000_9001;  // IE, IM7, IM4
  localparam logic [31:0] SX = 32'h0000_8003;  // IE, EXL, IM7
  localparam logic [31:0] S2 = 32'h0000_8001;  // IE, IM7
  localparam logic [31:0] S3 = 32'h0000_0101;  // IE, IM0
  localparam logic [31:0] IE = 32'h8000_2000;

  vec_t tbl[$];
  vec_t idle_v;
  int   k;

  initial begin
    // Reset state
    rst = 1'b0;
    inst_epc = IE;
    idle_v = mk(6'h00, 0, 2'b00, 32'h0, 0, EC_NONE, 0, 0, 1, 0, 8'h00, EC_NONE, 0, 0, 0, 0);
    drive(idle_v);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", outs(), exp_outs(8'h00, EC_NONE, 32'h0, 32'h0, 0, 0, 0));
    rst = 1'b1;

    // hw  tmr sw  status req code   epc           bv            iv jmp  cause code     epc           bv            stl fl
    tbl.push_back(mk(6'h00, 0, 2'b00, S0, 0, EC_NONE, 0, 0, 1, 0, 8'h00, EC_NONE, 0, 0, 0, 0));
    tbl.push_back(mk(6'h00, 0, 2'b00, S0, 1, EC_TLBL, 32'h8000_1000, 32'h0040_0010, 1, 0, 8'h00, EC_NONE, 0, 0, 1, 0));
    tbl.push_back(mk(6'h00, 0, 2'b00, S0, 0, EC_NONE, 0, 0, 1, 0, 8'h00, EC_TLBL, 32'h8000_1000, 32'h0040_0010, 1, 1));
    tbl.push_back(mk(6'h00, 0, 2'b00, S0, 0, EC_NONE, 0, 0, 1, 1, 8'h00, EC_NONE, 32'h8000_1000, 32'h0040_0010, 1, 1));
    tbl.push_back(mk(6'h00, 0, 2'b00, S0, 0, EC_NONE, 0, 0, 1, 0, 8'h00, EC_NONE, 32'h8000_1000, 32'h0040_0010, 0, 0));
    // hw_int[2] through the two-flop synchronizer, then dropped after capture
    tbl.push_back(mk(6'h04, 0, 2'b00, S0, 0, EC_NONE, 0, 0, 1, 0, 8'h00, EC_NONE, 32'h8000_1000, 32'h0040_0010, 0, 0));
    tbl.push_back(mk(6'h04, 0, 2'b00, S0, 0, EC_NONE, 0, 0, 1, 0, 8'h00, EC_NONE, 32'h8000_1000, 32'h0040_0010, 0, 0));
    tbl.push_back(mk(6'h04, 0, 2'b00, S0, 0, EC_NONE, 0, 0, 1, 0, 8'h10, EC_NONE, 32'h8000_1000, 32'h0040_0010, 1, 0));
    tbl.push_back(mk(6'h00, 0, 2'b00, S0, 0, EC_NONE, 0, 0, 1, 0, 8'h10, EC_INT, IE, 32'h0, 1, 1));
    tbl.push_back(mk(6'h00, 0, 2'b00, S0, 0, EC_NONE, 0, 0, 1, 1, 8'h10, EC_NONE, IE, 32'h0, 1, 1));
    tbl.push_back(mk(6'h00, 0, 2'b00, S0, 0, EC_NONE, 0, 0, 1, 0, 8'h00, EC_NONE, IE, 32'h0, 0, 0));
    // SYS beats a simultaneous timer interrupt; interrupt follows on the first IDLE cycle
    tbl.push_back(mk(6'h00, 1, 2'b00, S1, 1, EC_SYS, 32'h8000_3000, 32'h0000_1234, 1, 0, 8'h80, EC_NONE, IE, 32'h0, 1, 0));
    tbl.push_back(mk(6'h00, 1, 2'b00, S1, 0, EC_NONE, 0, 0, 1, 0, 8'h80, EC_SYS, 32'h8000_3000, 32'h0000_1234, 1, 1));
    tbl.push_back(mk(6'h00, 1, 2'b00, S1, 0, EC_NONE, 0, 0, 1, 1, 8'h80, EC_NONE, 32'h8000_3000, 32'h0000_1234, 1, 1));
    tbl.push_back(mk(6'h00, 1, 2'b00, S1, 0, EC_NONE, 0, 0, 1, 0, 8'h80, EC_NONE, 32'h8000_3000, 32'h0000_1234, 1, 0));
    tbl.push_back(mk(6'h00, 1, 2'b00, S1, 0, EC_NONE, 0, 0, 1, 0, 8'h80, EC_INT, IE, 32'h0, 1, 1));
    tbl.push_back(mk(6'h00, 1, 2'b00, S1, 0, EC_NONE, 0, 0, 1, 1, 8'h80, EC_NONE, IE, 32'h0, 1, 1));
    tbl.push_back(mk(6'h00, 0, 2'b00, S1, 0, EC_NONE, 0, 0, 1, 0, 8'h00, EC_NONE, IE, 32'h0, 0, 0));
    // EXL masks the timer; ERET passes through, then the interrupt is taken once EXL clears
    tbl.push_back(mk(6'h00, 1, 2'b00, SX, 0, EC_NONE, 0, 0, 1, 0, 8'h80, EC_NONE, IE, 32'h0, 0, 0));
    tbl.push_back(mk(6'h00, 1, 2'b00, SX, 0, EC_NONE, 0, 0, 1, 0, 8'h80, EC_NONE, IE, 32'h0, 0, 0));
    tbl.push_back(mk(6'h00, 1, 2'b00, SX, 1, EC_ERET, 32'h8000_4000, 32'hDEAD_BEEF, 1, 0, 8'h80, EC_NONE, IE, 32'h0, 1, 0));
    tbl.push_back(mk(6'h00, 1, 2'b00, S2, 0, EC_NONE, 0, 0, 1, 0, 8'h80, EC_ERET, 32'h8000_4000, 32'hDEAD_BEEF, 1, 1));
    tbl.push_back(mk(6'h00, 1, 2'b00, S2, 0, EC_NONE, 0, 0, 1, 1, 8'h80, EC_NONE, 32'h8000_4000, 32'hDEAD_BEEF, 1, 1));
    tbl.push_back(mk(6'h00, 1, 2'b00, S2, 0, EC_NONE, 0, 0, 1, 0, 8'h80, EC_NONE, 32'h8000_4000, 32'hDEAD_BEEF, 1, 0));
    tbl.push_back(mk(6'h00, 1, 2'b00, S2, 0, EC_NONE, 0, 0, 1, 0, 8'h80, EC_INT, IE, 32'h0, 1, 1));
    tbl.push_back(mk(6'h00, 1, 2'b00, S2, 0, EC_NONE, 0, 0, 1, 1, 8'h80, EC_NONE, IE, 32'h0, 1, 1));
    tbl.push_back(mk(6'h00, 0, 2'b00, S2, 0, EC_NONE, 0, 0, 1, 0, 8'h00, EC_NONE, IE, 32'h0, 0, 0));
    // Software interrupt, held off by a bubble in MEM
    tbl.push_back(mk(6'h00, 0, 2'b01, S3, 0, EC_NONE, 0, 0, 0, 0, 8'h01, EC_NONE, IE, 32'h0, 0, 0));
    tbl.push_back(mk(6'h00, 0, 2'b01, S3, 0, EC_NONE, 0, 0, 1, 0, 8'h01, EC_NONE, IE, 32'h0, 1, 0));
    tbl.push_back(mk(6'h00, 0, 2'b00, S3, 0, EC_NONE, 0, 0, 1, 0, 8'h00, EC_INT, IE, 32'h0, 1, 1));
    tbl.push_back(mk(6'h00, 0, 2'b00, S3, 0, EC_NONE, 0, 0, 1, 1, 8'h00, EC_NONE, IE, 32'h0, 1, 1));
    // Back-to-back: request accepted in the first IDLE cycle after WAIT
    tbl.push_back(mk(6'h00, 0, 2'b00, S3, 1, EC_TLBL, 32'h8000_5000, 32'h0000_0010, 1, 0, 8'h00, EC_NONE, IE, 32'h0, 1, 0));
    tbl.push_back(mk(6'h00, 0, 2'b00, S3, 0, EC_NONE, 0, 0, 1, 0, 8'h00, EC_TLBL, 32'h8000_5000, 32'h0000_0010, 1, 1));
    tbl.push_back(mk(6'h00, 0, 2'b00, S3, 0, EC_NONE, 0, 0, 1, 1, 8'h00, EC_NONE, 32'h8000_5000, 32'h0000_0010, 1, 1));
    tbl.push_back(mk(6'h00, 0, 2'b00, S3, 0, EC_NONE, 0, 0, 1, 0, 8'h00, EC_NONE, 32'h8000_5000, 32'h0000_0010, 0, 0));

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      drive(tbl[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), outs(),
            exp_outs(tbl[i].e_cause, tbl[i].e_code, tbl[i].e_epc, tbl[i].e_bv,
                     tbl[i].e_stall, tbl[i].e_flush, 1'b0));
    end

    // Timeout: exc_jmp_flag never arrives
    @(posedge clk); #1;
    drive(idle_v);
    req_valid = 1'b1; req_code = EC_SYS; req_epc = 32'h8000_6000; req_badvaddr = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("timeout_issue", outs(), exp_outs(8'h00, EC_SYS, 32'h8000_6000, 32'h0, 1, 1, 0));
    k = 11;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (timeout_err) begin
        k = c;
        break;
      end
    end
    check("timeout_delay", 96'(k), 96'd4);
    check("timeout_pulse", outs(), exp_outs(8'h00, EC_NONE, 32'h8000_6000, 32'h0, 1, 1, 1));
    @(posedge clk); #1;
    @(negedge clk);
    check("timeout_idle", outs(), exp_outs(8'h00, EC_NONE, 32'h8000_6000, 32'h0, 0, 0, 0));

    // Synchronizers fill, then reset asserted for one cycle while in WAIT
    @(posedge clk); #1;
    hw_int = 6'h3f;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("all_hw_lines", 96'(cause_ip), 96'h0FC);
    @(posedge clk); #1;
    req_valid = 1'b1; req_code = EC_TLBL; req_epc = 32'h8000_7000; req_badvaddr = 32'h0000_0020;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("in_wait", outs(), exp_outs(8'hFC, EC_NONE, 32'h8000_7000, 32'h0000_0020, 1, 1, 0));
    @(posedge clk); #1;
    rst = 1'b0;
    hw_int = 6'h00;
    @(negedge clk);
    check("reset_in_wait", outs(), exp_outs(8'h00, EC_NONE, 32'h0, 32'h0, 0, 0, 0));
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("after_reset%0d", c), outs(), exp_outs(8'h00, EC_NONE, 32'h0, 32'h0, 0, 0, 0));
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
